// File: rtl/alu_exec_unit_pkg.sv
// Opcode encoding and operand-selection helpers shared by the ALU execution unit.
package alu_exec_unit_pkg;

    localparam int OPT_W = 6;
    localparam int CNT_W = 32;

    typedef enum logic [OPT_W-1:0] {
        OPT_NONE  = 6'd0,
        OPT_LUI   = 6'd1,
        OPT_AUIPC = 6'd2,
        OPT_JAL   = 6'd3,
        OPT_JALR  = 6'd4,
        OPT_BEQ   = 6'd5,
        OPT_BNE   = 6'd6,
        OPT_BLT   = 6'd7,
        OPT_BGE   = 6'd8,
        OPT_BLTU  = 6'd9,
        OPT_BGEU  = 6'd10,
        OPT_ADD   = 6'd11,
        OPT_SUB   = 6'd12,
        OPT_SLL   = 6'd13,
        OPT_SLT   = 6'd14,
        OPT_SLTU  = 6'd15,
        OPT_XOR   = 6'd16,
        OPT_SRL   = 6'd17,
        OPT_SRA   = 6'd18,
        OPT_OR    = 6'd19,
        OPT_AND   = 6'd20,
        OPT_ADDI  = 6'd21,
        OPT_SLTI  = 6'd22,
        OPT_SLTIU = 6'd23,
        OPT_XORI  = 6'd24,
        OPT_ORI   = 6'd25,
        OPT_ANDI  = 6'd26,
        OPT_SLLI  = 6'd27,
        OPT_SRLI  = 6'd28,
        OPT_SRAI  = 6'd29
    } opt_e;

    function automatic logic is_branch_opt(input logic [OPT_W-1:0] o);
        return o inside {OPT_BEQ, OPT_BNE, OPT_BLT, OPT_BGE, OPT_BLTU, OPT_BGEU};
    endfunction

    // PC-relative ops also take the immediate as operand B (pc arrives on val1).
    function automatic logic uses_imm(input logic [OPT_W-1:0] o);
        return o inside {OPT_ADDI, OPT_SLTI, OPT_SLTIU, OPT_XORI, OPT_ORI, OPT_ANDI,
                         OPT_SLLI, OPT_SRLI, OPT_SRAI, OPT_LUI, OPT_AUIPC, OPT_JAL, OPT_JALR};
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result and branch outcome for one op, no state.
// Latency 0; no flow control.
module alu_core
    import alu_exec_unit_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [OPT_W-1:0]  opt,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [WORD_W-1:0] val1,
    input  logic [WORD_W-1:0] val2,
    output logic [WORD_W-1:0] result,
    output logic              taken
);

    logic [4:0] shamt;
    logic       cond;

    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (opt)
            OPT_ADD, OPT_ADDI:             result = a + b;
            OPT_SUB:                       result = a - b;
            OPT_AND, OPT_ANDI:             result = a & b;
            OPT_OR, OPT_ORI:               result = a | b;
            OPT_XOR, OPT_XORI:             result = a ^ b;
            OPT_SLL, OPT_SLLI:             result = a << shamt;
            OPT_SRL, OPT_SRLI:             result = a >> shamt;
            OPT_SRA, OPT_SRAI:             result = WORD_W'($signed(a) >>> shamt);
            OPT_SLT, OPT_SLTI:             result = WORD_W'($signed(a) < $signed(b));
            OPT_SLTU, OPT_SLTIU:           result = WORD_W'(a < b);
            OPT_LUI:                       result = b;
            OPT_AUIPC, OPT_JAL, OPT_JALR:  result = a + b;
            default:                       result = '0;
        endcase
    end

    // Branches always compare the raw register operands, never the immediate.
    always_comb begin
        cond = 1'b0;
        case (opt)
            OPT_BEQ:  cond = (val1 == val2);
            OPT_BNE:  cond = (val1 != val2);
            OPT_BLT:  cond = ($signed(val1) <  $signed(val2));
            OPT_BGE:  cond = ($signed(val1) >= $signed(val2));
            OPT_BLTU: cond = (val1 <  val2);
            OPT_BGEU: cond = (val1 >= val2);
            default:  cond = 1'b0;
        endcase
    end

    assign taken = is_branch_opt(opt) & cond;

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: capture (S1) then execute (S2), results broadcast on the CDB; latency 2.
// No backpressure, accepts every rdy cycle; rdy=0 freezes all state, rb flushes both stages.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROB_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rb,
    input  logic              alu_ena,
    input  logic [OPT_W-1:0]  alu_opt,
    input  logic [WORD_W-1:0] alu_val1,
    input  logic [WORD_W-1:0] alu_val2,
    input  logic [WORD_W-1:0] alu_imm,
    input  logic [ROB_W-1:0]  alu_rob_idx,
    output logic              cdb_alu_valid,
    output logic [ROB_W-1:0]  cdb_alu_src,
    output logic [WORD_W-1:0] cdb_alu_val,
    output logic              cdb_alu_taken,
    output logic              alu_busy,
    output logic [CNT_W-1:0]  alu_issue_cnt
);

    logic              s1_valid_q, s1_valid_d;
    logic [OPT_W-1:0]  s1_opt_q,   s1_opt_d;
    logic [WORD_W-1:0] s1_val1_q,  s1_val1_d;
    logic [WORD_W-1:0] s1_val2_q,  s1_val2_d;
    logic [WORD_W-1:0] s1_imm_q,   s1_imm_d;
    logic [ROB_W-1:0]  s1_rob_q,   s1_rob_d;

    logic              s2_valid_q, s2_valid_d;
    logic [ROB_W-1:0]  s2_rob_q,   s2_rob_d;
    logic [WORD_W-1:0] s2_val_q,   s2_val_d;
    logic              s2_taken_q, s2_taken_d;

    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic [WORD_W-1:0] op_b;
    logic [WORD_W-1:0] core_result;
    logic              core_taken;

    assign op_b = uses_imm(s1_opt_q) ? s1_imm_q : s1_val2_q;

    alu_core #(.WORD_W(WORD_W)) u_core (
        .opt    (s1_opt_q),
        .a      (s1_val1_q),
        .b      (op_b),
        .val1   (s1_val1_q),
        .val2   (s1_val2_q),
        .result (core_result),
        .taken  (core_taken)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_opt_d   = s1_opt_q;
        s1_val1_d  = s1_val1_q;
        s1_val2_d  = s1_val2_q;
        s1_imm_d   = s1_imm_q;
        s1_rob_d   = s1_rob_q;
        s2_valid_d = s2_valid_q;
        s2_rob_d   = s2_rob_q;
        s2_val_d   = s2_val_q;
        s2_taken_d = s2_taken_q;
        cnt_d      = cnt_q;

        if (rdy) begin
            // Tag 0 means "no tag": such an issue is counted but never enters the pipe.
            s1_valid_d = alu_ena && (alu_rob_idx != '0);
            s1_opt_d   = alu_opt;
            s1_val1_d  = alu_val1;
            s1_val2_d  = alu_val2;
            s1_imm_d   = alu_imm;
            s1_rob_d   = alu_rob_idx;
            s2_valid_d = s1_valid_q;
            s2_rob_d   = s1_rob_q;
            s2_val_d   = core_result;
            s2_taken_d = core_taken;
            if (alu_ena) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (rb) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            cnt_d      = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_opt_q   <= '0;
            s1_val1_q  <= '0;
            s1_val2_q  <= '0;
            s1_imm_q   <= '0;
            s1_rob_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_rob_q   <= '0;
            s2_val_q   <= '0;
            s2_taken_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_opt_q   <= s1_opt_d;
            s1_val1_q  <= s1_val1_d;
            s1_val2_q  <= s1_val2_d;
            s1_imm_q   <= s1_imm_d;
            s1_rob_q   <= s1_rob_d;
            s2_valid_q <= s2_valid_d;
            s2_rob_q   <= s2_rob_d;
            s2_val_q   <= s2_val_d;
            s2_taken_q <= s2_taken_d;
            cnt_q      <= cnt_d;
        end
    end

    // A flush kills the result sitting in S2 in the same cycle, so nothing stale reaches the ROB.
    assign cdb_alu_valid = s2_valid_q & rdy & ~rb & ~rst;
    assign cdb_alu_src   = s2_rob_q;
    assign cdb_alu_val   = s2_val_q;
    assign cdb_alu_taken = s2_taken_q;
    assign alu_busy      = s1_valid_q | s2_valid_q;
    assign alu_issue_cnt = cnt_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and random checks of alu_exec_unit against a queue-based reference model.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, rb, alu_ena;
    logic [5:0]  alu_opt;
    logic [31:0] alu_val1, alu_val2, alu_imm;
    logic [3:0]  alu_rob_idx;
    logic        cdb_alu_valid, cdb_alu_taken, alu_busy;
    logic [3:0]  cdb_alu_src;
    logic [31:0] cdb_alu_val, alu_issue_cnt;

    alu_exec_unit #(.WORD_W(32), .ROB_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .rb            (rb),
        .alu_ena       (alu_ena),
        .alu_opt       (alu_opt),
        .alu_val1      (alu_val1),
        .alu_val2      (alu_val2),
        .alu_imm       (alu_imm),
        .alu_rob_idx   (alu_rob_idx),
        .cdb_alu_valid (cdb_alu_valid),
        .cdb_alu_src   (cdb_alu_src),
        .cdb_alu_val   (cdb_alu_val),
        .cdb_alu_taken (cdb_alu_taken),
        .alu_busy      (alu_busy),
        .alu_issue_cnt (alu_issue_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] val;
        logic        taken;
        int          age;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_cnt;
    int          checks = 0;
    int          failures = 0;

    logic        obs_valid, obs_taken, obs_busy;
    logic [3:0]  obs_src;
    logic [31:0] obs_val, obs_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference semantics straight from the ISA definitions.
    function automatic void ref_alu(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                                    input logic [31:0] imm, output logic [31:0] val, output logic t);
        val = 32'd0;
        t   = 1'b0;
        case (op)
            OPT_ADD:   val = v1 + v2;
            OPT_ADDI:  val = v1 + imm;
            OPT_SUB:   val = v1 - v2;
            OPT_AND:   val = v1 & v2;
            OPT_ANDI:  val = v1 & imm;
            OPT_OR:    val = v1 | v2;
            OPT_ORI:   val = v1 | imm;
            OPT_XOR:   val = v1 ^ v2;
            OPT_XORI:  val = v1 ^ imm;
            OPT_SLL:   val = v1 << v2[4:0];
            OPT_SLLI:  val = v1 << imm[4:0];
            OPT_SRL:   val = v1 >> v2[4:0];
            OPT_SRLI:  val = v1 >> imm[4:0];
            OPT_SRA:   val = 32'($signed(v1) >>> v2[4:0]);
            OPT_SRAI:  val = 32'($signed(v1) >>> imm[4:0]);
            OPT_SLT:   val = ($signed(v1) < $signed(v2))  ? 32'd1 : 32'd0;
            OPT_SLTI:  val = ($signed(v1) < $signed(imm)) ? 32'd1 : 32'd0;
            OPT_SLTU:  val = (v1 < v2)  ? 32'd1 : 32'd0;
            OPT_SLTIU: val = (v1 < imm) ? 32'd1 : 32'd0;
            OPT_LUI:   val = imm;
            OPT_AUIPC, OPT_JAL, OPT_JALR: val = v1 + imm;
            OPT_BEQ:   t = (v1 == v2);
            OPT_BNE:   t = (v1 != v2);
            OPT_BLT:   t = ($signed(v1) <  $signed(v2));
            OPT_BGE:   t = ($signed(v1) >= $signed(v2));
            OPT_BLTU:  t = (v1 <  v2);
            OPT_BGEU:  t = (v1 >= v2);
            default:   val = 32'd0;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; rb = 1'b0; alu_ena = 1'b0; alu_opt = 6'd0;
        alu_val1 = 32'd0; alu_val2 = 32'd0; alu_imm = 32'd0; alu_rob_idx = 4'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        pend.delete();
        exp_cnt = 32'd0;
        chk("rst_valid", 32'(cdb_alu_valid), 32'd0);
        chk("rst_src",   32'(cdb_alu_src),   32'd0);
        chk("rst_val",   cdb_alu_val,        32'd0);
        chk("rst_taken", 32'(cdb_alu_taken), 32'd0);
        chk("rst_busy",  32'(alu_busy),      32'd0);
        chk("rst_cnt",   alu_issue_cnt,      32'd0);
    endtask

    // One clock cycle: drive, check mid-cycle against the model, then advance the model at the edge.
    task automatic step(input logic ena, input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] imm, input logic [3:0] tag, input logic rdy_v, input logic rb_v);
        logic        exp_valid;
        pend_t       e;
        alu_ena = ena; alu_opt = op; alu_val1 = v1; alu_val2 = v2; alu_imm = imm;
        alu_rob_idx = tag; rdy = rdy_v; rb = rb_v;
        @(negedge clk);
        obs_valid = cdb_alu_valid; obs_src = cdb_alu_src; obs_val = cdb_alu_val;
        obs_taken = cdb_alu_taken; obs_busy = alu_busy; obs_cnt = alu_issue_cnt;
        exp_valid = rdy_v && !rb_v && (pend.size() > 0) && (pend[0].age == 2);
        chk("cdb_valid", 32'(obs_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("cdb_src",   32'(obs_src),   32'(pend[0].tag));
            chk("cdb_val",   obs_val,        pend[0].val);
            chk("cdb_taken", 32'(obs_taken), 32'(pend[0].taken));
        end
        chk("busy", 32'(obs_busy), 32'(pend.size() != 0));
        chk("cnt",  obs_cnt,       exp_cnt);
        @(posedge clk);
        if (rb_v) begin
            pend.delete();
        end else if (rdy_v) begin
            if (pend.size() > 0 && pend[0].age == 2) void'(pend.pop_front());
            foreach (pend[i]) pend[i].age++;
            if (ena) begin
                exp_cnt++;
                if (tag != 4'd0) begin
                    ref_alu(op, v1, v2, imm, e.val, e.taken);
                    e.tag = tag;
                    e.age = 1;
                    pend.push_back(e);
                end
            end
        end
        #1;
    endtask

    task automatic idle(input logic rdy_v);
        step(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 4'd0, rdy_v, 1'b0);
    endtask

    initial begin
        int accepted;
        int iters;
        logic [5:0]  r_op;
        logic [31:0] r_v1, r_v2, r_imm;
        logic        r_ena, r_rdy;

        // 1: single ADDI, latency 2
        do_reset();
        step(1'b1, OPT_ADDI, 32'd5, 32'd0, 32'hFFFF_FFFD, 4'd3, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("t1_valid", 32'(obs_valid), 32'd1);
        chk("t1_src",   32'(obs_src),   32'd3);
        chk("t1_val",   obs_val,        32'd2);
        chk("t1_taken", 32'(obs_taken), 32'd0);
        idle(1'b1);

        // 2: back-to-back SUB / SRA / SLTU
        step(1'b1, OPT_SUB,  32'd0,         32'd1,         32'd0, 4'd1, 1'b1, 1'b0);
        step(1'b1, OPT_SRA,  32'h8000_0000, 32'd4,         32'd0, 4'd2, 1'b1, 1'b0);
        step(1'b1, OPT_SLTU, 32'd1,         32'hFFFF_FFFF, 32'd0, 4'd3, 1'b1, 1'b0);
        chk("t2_sub", obs_val, 32'hFFFF_FFFF);
        idle(1'b1);
        chk("t2_sra", obs_val, 32'hF800_0000);
        idle(1'b1);
        chk("t2_sltu", obs_val, 32'd1);

        // 3: signed vs unsigned branch compare
        step(1'b1, OPT_BLT,  32'hFFFF_FFFF, 32'd1, 32'd0, 4'd5, 1'b1, 1'b0);
        step(1'b1, OPT_BLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'd6, 1'b1, 1'b0);
        idle(1'b1);
        chk("t3_blt_taken", 32'(obs_taken), 32'd1);
        chk("t3_blt_val",   obs_val,        32'd0);
        idle(1'b1);
        chk("t3_bltu_src",   32'(obs_src),   32'd6);
        chk("t3_bltu_taken", 32'(obs_taken), 32'd0);
        idle(1'b1);

        // 4: freeze for three cycles
        do_reset();
        step(1'b1, OPT_ADD, 32'd1, 32'd1, 32'd0, 4'd7, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            chk("t4_frozen_valid", 32'(obs_valid), 32'd0);
        end
        idle(1'b1);
        idle(1'b1);
        chk("t4_valid", 32'(obs_valid), 32'd1);
        chk("t4_src",   32'(obs_src),   32'd7);
        chk("t4_val",   obs_val,        32'd2);
        idle(1'b1);
        chk("t4_once", 32'(obs_valid), 32'd0);
        chk("t4_cnt",  obs_cnt,         32'd1);

        // 5: rollback together with the third issue
        do_reset();
        step(1'b1, OPT_ADD, 32'd1, 32'd2, 32'd0, 4'd1, 1'b1, 1'b0);
        step(1'b1, OPT_ADD, 32'd3, 32'd4, 32'd0, 4'd2, 1'b1, 1'b0);
        step(1'b1, OPT_ADD, 32'd5, 32'd6, 32'd0, 4'd3, 1'b1, 1'b1);
        chk("t5_rb_valid", 32'(obs_valid), 32'd0);
        idle(1'b1);
        chk("t5_busy",  32'(obs_busy),  32'd0);
        chk("t5_valid", 32'(obs_valid), 32'd0);
        chk("t5_cnt",   obs_cnt,        32'd2);
        idle(1'b1);

        // tag 0 issue is dropped but counted
        do_reset();
        step(1'b1, OPT_ADD, 32'd1, 32'd1, 32'd0, 4'd0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("t0_valid", 32'(obs_valid), 32'd0);
        chk("t0_cnt",   obs_cnt,        32'd1);

        // 6: 1000 accepted random ops with random freezes
        do_reset();
        accepted = 0;
        iters = 0;
        while (accepted < 1000 && iters < 5000) begin
            r_op  = 6'($urandom_range(0, 31));
            r_v1  = $urandom;
            r_v2  = ($urandom_range(0, 3) == 0) ? r_v1 : $urandom;
            r_imm = $urandom;
            r_ena = ($urandom_range(0, 9) != 0);
            r_rdy = ($urandom_range(0, 6) != 0);
            if (r_ena && r_rdy) accepted++;
            step(r_ena, r_op, r_v1, r_v2, r_imm, 4'($urandom_range(1, 15)), r_rdy, 1'b0);
            iters++;
        end
        chk("t6_accepted", 32'(accepted), 32'd1000);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("t6_cnt", obs_cnt, 32'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
